// File: rtl/iir_cfg_pkg.sv
// Shared constants and types for the notch IIR chain configuration path.
// Stage indices double as bit positions in stage masks and bypass vectors.
package iir_cfg_pkg;

  localparam int unsigned IIR_2_4_NOTCH = 2;
  localparam int unsigned IIR_2_NOTCH   = 1;
  localparam int unsigned IIR_1_NOTCH   = 0;

  localparam int unsigned NUM_COEFF_DEPTH = 3;
  localparam int unsigned DEN_COEFF_DEPTH = 2;
  localparam int unsigned WORDS_PER_STAGE = NUM_COEFF_DEPTH + DEN_COEFF_DEPTH;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    COLLECT,
    WRITE,
    FLUSH,
    DONE
  } seq_state_t;

  // Chain order is 2.4 MHz, then 1 MHz, then 2 MHz; caller guarantees mask != 0.
  function automatic logic [1:0] first_pending(input logic [2:0] mask);
    if (mask[IIR_2_4_NOTCH]) begin
      return 2'(IIR_2_4_NOTCH);
    end else if (mask[IIR_1_NOTCH]) begin
      return 2'(IIR_1_NOTCH);
    end else begin
      return 2'(IIR_2_NOTCH);
    end
  endfunction

endpackage

// File: rtl/iir_coeff_sequencer.sv
// Coefficient reload sequencer for the three-stage notch IIR chain: collects five words per
// selected stage, pulses that stage's write enables and holds it in bypass until it has flushed.
module iir_coeff_sequencer
  import iir_cfg_pkg::*;
#(
  parameter int unsigned COEFF_WIDTH   = 20,
  parameter int unsigned FLUSH_SAMPLES = 2,
  parameter int unsigned FLUSH_CNT_W   = 4
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           valid_in,
  input  logic                                           cfg_start,
  input  logic [2:0]                                     cfg_stage_mask,
  input  logic                                           cfg_abort,
  input  logic                                           coeff_valid,
  input  logic [COEFF_WIDTH-1:0]                         coeff_data,
  output logic                                           coeff_ready,
  input  logic [2:0]                                     bypass_req,
  output logic                                           bypass_2_4,
  output logic                                           bypass_2,
  output logic                                           bypass_1,
  output logic [NUM_COEFF_DEPTH-1:0][COEFF_WIDTH-1:0]    num_coeff_out,
  output logic [DEN_COEFF_DEPTH-1:0][COEFF_WIDTH-1:0]    den_coeff_out,
  output logic                                           num_coeff_2_4_wr_en,
  output logic                                           den_coeff_2_4_wr_en,
  output logic                                           num_coeff_2_wr_en,
  output logic                                           den_coeff_2_wr_en,
  output logic                                           num_coeff_1_wr_en,
  output logic                                           den_coeff_1_wr_en,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           aborted
);

  localparam logic [FLUSH_CNT_W-1:0] FlushTarget = FLUSH_CNT_W'(FLUSH_SAMPLES);
  localparam logic [FLUSH_CNT_W-1:0] FlushOne    = FLUSH_CNT_W'(1);
  localparam logic [2:0]             LastWord    = 3'(WORDS_PER_STAGE - 1);

  seq_state_t                                  state_q;
  logic [2:0]                                  mask_q;
  logic [2:0]                                  force_q;
  logic [2:0]                                  bypass_q;
  logic [1:0]                                  sel_q;
  logic [2:0]                                  cnt_q;
  logic [FLUSH_CNT_W-1:0]                      flush_q;
  logic [NUM_COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] num_q;
  logic [DEN_COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] den_q;
  logic                                        done_q;
  logic                                        aborted_q;
  logic                                        handshake;
  logic [2:0]                                  wr_sel;

  assign handshake = coeff_valid & coeff_ready;

  // An abort arriving during WRITE still suppresses the write enables of that cycle.
  always_comb begin
    wr_sel = 3'b000;
    if (state_q == WRITE && !cfg_abort) begin
      wr_sel = 3'b001 << sel_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mask_q    <= 3'b000;
      force_q   <= 3'b000;
      bypass_q  <= 3'b000;
      sel_q     <= 2'd0;
      cnt_q     <= 3'd0;
      flush_q   <= '0;
      num_q     <= '0;
      den_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      bypass_q  <= bypass_req | force_q;

      if (cfg_abort && state_q != IDLE) begin
        state_q   <= IDLE;
        aborted_q <= 1'b1;
        force_q   <= 3'b000;
        mask_q    <= 3'b000;
        cnt_q     <= 3'd0;
        flush_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (cfg_start) begin
              if (cfg_stage_mask != 3'b000) begin
                mask_q  <= cfg_stage_mask;
                state_q <= SELECT;
              end else begin
                state_q <= DONE;
              end
            end
          end
          SELECT: begin
            if (mask_q == 3'b000) begin
              state_q <= DONE;
            end else begin
              sel_q   <= first_pending(mask_q);
              force_q <= 3'b001 << first_pending(mask_q);
              cnt_q   <= 3'd0;
              state_q <= COLLECT;
            end
          end
          COLLECT: begin
            if (handshake) begin
              unique case (cnt_q)
                3'd0:    num_q[0] <= coeff_data;
                3'd1:    num_q[1] <= coeff_data;
                3'd2:    num_q[2] <= coeff_data;
                3'd3:    den_q[0] <= coeff_data;
                3'd4:    den_q[1] <= coeff_data;
                default: ;
              endcase
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == LastWord) begin
                state_q <= WRITE;
              end
            end
          end
          WRITE: begin
            flush_q <= '0;
            state_q <= FLUSH;
          end
          FLUSH: begin
            if (flush_q == FlushTarget) begin
              force_q <= 3'b000;
              mask_q  <= mask_q & ~(3'b001 << sel_q);
              state_q <= SELECT;
            end else if (valid_in) begin
              flush_q <= flush_q + FlushOne;
            end
          end
          DONE: begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign coeff_ready = (state_q == COLLECT);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign aborted     = aborted_q;

  assign bypass_2_4 = bypass_q[IIR_2_4_NOTCH];
  assign bypass_2   = bypass_q[IIR_2_NOTCH];
  assign bypass_1   = bypass_q[IIR_1_NOTCH];

  assign num_coeff_out = num_q;
  assign den_coeff_out = den_q;

  assign num_coeff_2_4_wr_en = wr_sel[IIR_2_4_NOTCH];
  assign den_coeff_2_4_wr_en = wr_sel[IIR_2_4_NOTCH];
  assign num_coeff_2_wr_en   = wr_sel[IIR_2_NOTCH];
  assign den_coeff_2_wr_en   = wr_sel[IIR_2_NOTCH];
  assign num_coeff_1_wr_en   = wr_sel[IIR_1_NOTCH];
  assign den_coeff_1_wr_en   = wr_sel[IIR_1_NOTCH];

endmodule

// File: tb/tb_iir_coeff_sequencer.sv
// Bench for iir_coeff_sequencer: random coefficient words and gaps, checked against a
// transaction-level model of which stages get written, in which order, with which words.
module tb_iir_coeff_sequencer;

  localparam int W  = 20;
  localparam int FS = 2;

  typedef struct packed {
    logic [1:0]        stage;
    logic [4:0][W-1:0] w;
  } wr_rec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_in = 1'b0;
  logic         cfg_start = 1'b0;
  logic [2:0]   cfg_stage_mask = 3'b000;
  logic         cfg_abort = 1'b0;
  logic         coeff_valid = 1'b0;
  logic [W-1:0] coeff_data = '0;
  logic [2:0]   bypass_req = 3'b000;

  logic              coeff_ready;
  logic              bypass_2_4, bypass_2, bypass_1;
  logic [2:0][W-1:0] num_coeff_out;
  logic [1:0][W-1:0] den_coeff_out;
  logic              num_coeff_2_4_wr_en, den_coeff_2_4_wr_en;
  logic              num_coeff_2_wr_en, den_coeff_2_wr_en;
  logic              num_coeff_1_wr_en, den_coeff_1_wr_en;
  logic              busy, done, aborted;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  logic [W-1:0] words[$];
  wr_rec_t      exp_q[$];
  wr_rec_t      obs_q[$];
  logic [2:0]   byp_seen = 3'b000;

  iir_coeff_sequencer #(
    .COEFF_WIDTH  (W),
    .FLUSH_SAMPLES(FS),
    .FLUSH_CNT_W  (4)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .valid_in           (valid_in),
    .cfg_start          (cfg_start),
    .cfg_stage_mask     (cfg_stage_mask),
    .cfg_abort          (cfg_abort),
    .coeff_valid        (coeff_valid),
    .coeff_data         (coeff_data),
    .coeff_ready        (coeff_ready),
    .bypass_req         (bypass_req),
    .bypass_2_4         (bypass_2_4),
    .bypass_2           (bypass_2),
    .bypass_1           (bypass_1),
    .num_coeff_out      (num_coeff_out),
    .den_coeff_out      (den_coeff_out),
    .num_coeff_2_4_wr_en(num_coeff_2_4_wr_en),
    .den_coeff_2_4_wr_en(den_coeff_2_4_wr_en),
    .num_coeff_2_wr_en  (num_coeff_2_wr_en),
    .den_coeff_2_wr_en  (den_coeff_2_wr_en),
    .num_coeff_1_wr_en  (num_coeff_1_wr_en),
    .den_coeff_1_wr_en  (den_coeff_1_wr_en),
    .busy               (busy),
    .done               (done),
    .aborted            (aborted)
  );

  always #5 clk = ~clk;

  // One chain sample strobe every four cycles.
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 valid_in = 1'b1;
      @(posedge clk);
      #1 valid_in = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: record writes, count pulses, and check flush length per written stage.
  logic [2:0] prev_byp = 3'b000;
  int         arm = -1;
  int         strobes = 0;

  always @(negedge clk) begin
    logic [2:0] wn, wd, cur;
    wr_rec_t    rec;
    wn  = {num_coeff_2_4_wr_en, num_coeff_2_wr_en, num_coeff_1_wr_en};
    wd  = {den_coeff_2_4_wr_en, den_coeff_2_wr_en, den_coeff_1_wr_en};
    cur = {bypass_2_4, bypass_2, bypass_1};
    if (!rst_n) begin
      arm = -1;
      prev_byp = 3'b000;
    end else begin
      byp_seen |= cur;
      if (done) done_cnt++;
      if (aborted) abort_cnt++;
      if (wn != 3'b000 || wd != 3'b000) begin
        chk("wr_pair", {61'd0, wn}, {61'd0, wd});
        chk("wr_onehot", {63'd0, $onehot(wn)}, 64'd1);
        rec.stage = wn[2] ? 2'd2 : (wn[1] ? 2'd1 : 2'd0);
        rec.w[0] = num_coeff_out[0];
        rec.w[1] = num_coeff_out[1];
        rec.w[2] = num_coeff_out[2];
        rec.w[3] = den_coeff_out[0];
        rec.w[4] = den_coeff_out[1];
        obs_q.push_back(rec);
        chk("force_at_write", {63'd0, cur[rec.stage]}, 64'd1);
        arm = int'(rec.stage);
        strobes = 0;
      end else if (arm >= 0) begin
        if (valid_in) strobes++;
        if (prev_byp[arm] && !cur[arm] && !bypass_req[arm]) begin
          chk("flush_len", 64'(strobes), 64'(FS));
          arm = -1;
        end else if (done || aborted) begin
          if (!bypass_req[arm]) chk("flush_release", {63'd0, cur[arm]}, 64'd0);
          arm = -1;
        end
      end
      prev_byp = cur;
    end
  end

  // Reference: selected stages in chain order 2.4 MHz (bit2), 1 MHz (bit0), 2 MHz (bit1),
  // each taking the next five words b0, b1, b2, a1, a2.
  task automatic plan(input logic [2:0] m);
    int order[3] = '{2, 0, 1};
    int k = 0;
    wr_rec_t rec;
    for (int i = 0; i < 3; i++) begin
      if (m[order[i]]) begin
        rec.stage = 2'(order[i]);
        for (int j = 0; j < 5; j++) rec.w[j] = words[5 * k + j];
        exp_q.push_back(rec);
        k++;
      end
    end
  endtask

  task automatic gen_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(W'($urandom));
  endtask

  task automatic start_cfg(input logic [2:0] m);
    @(posedge clk);
    #1 cfg_stage_mask = m;
    cfg_start = 1'b1;
    @(posedge clk);
    #1 cfg_start = 1'b0;
  endtask

  task automatic send_words(input int from, input int to, input int gap);
    int   t;
    logic hs;
    for (int i = from; i < to; i++) begin
      while (gap > 0 && int'($urandom_range(99)) < gap) begin
        coeff_valid = 1'b0;
        coeff_data  = W'($urandom);
        @(posedge clk);
        #1;
      end
      coeff_valid = 1'b1;
      coeff_data  = words[i];
      t = 0;
      do begin
        @(negedge clk);
        hs = coeff_ready;
        @(posedge clk);
        #1;
        t++;
      end while (!hs && t < 200);
      if (!hs) begin
        chk("handshake_timeout", 64'd0, 64'd1);
        coeff_valid = 1'b0;
        return;
      end
    end
    coeff_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int base = done_cnt;
    int t = 0;
    while (done_cnt == base && t < bound) begin
      @(negedge clk);
      t++;
    end
    chk("done_once", 64'(done_cnt - base), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({tag, "_stage"}, 64'(obs_q[i].stage), 64'(exp_q[i].stage));
      for (int j = 0; j < 5; j++) chk({tag, "_word"}, 64'(obs_q[i].w[j]), 64'(exp_q[i].w[j]));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_reload(input logic [2:0] m, input int gap, input string tag);
    gen_words(5 * $countones(m));
    plan(m);
    start_cfg(m);
    send_words(0, words.size(), gap);
    wait_done(2000);
    compare_writes(tag);
  endtask

  function automatic logic [63:0] ctrl_outs();
    return {51'd0, coeff_ready, bypass_2_4, bypass_2, bypass_1,
            num_coeff_2_4_wr_en, den_coeff_2_4_wr_en, num_coeff_2_wr_en, den_coeff_2_wr_en,
            num_coeff_1_wr_en, den_coeff_1_wr_en, busy, done, aborted};
  endfunction

  initial begin
    int base;
    int t;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ctrl", ctrl_outs(), 64'd0);
    chk("reset_num", 64'(num_coeff_out), 64'd0);
    chk("reset_den", 64'(den_coeff_out), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ctrl", ctrl_outs(), 64'd0);

    // All three stages, back-to-back words
    run_reload(3'b111, 0, "all");

    // 2 MHz only, fixed words including negatives, with valid gaps
    byp_seen = 3'b000;
    words.delete();
    words.push_back(20'h0FFFF);
    words.push_back(20'h80000);
    words.push_back(20'h7FFFF);
    words.push_back(20'hC0000);
    words.push_back(20'h00001);
    plan(3'b010);
    start_cfg(3'b010);
    send_words(0, 5, 40);
    wait_done(2000);
    compare_writes("s2");
    chk("s2_no_byp_2_4", {63'd0, byp_seen[2]}, 64'd0);
    chk("s2_no_byp_1", {63'd0, byp_seen[0]}, 64'd0);
    chk("s2_byp_2_seen", {63'd0, byp_seen[1]}, 64'd1);

    // Zero mask: done two cycles after cfg_start, nothing else moves
    byp_seen = 3'b000;
    base = done_cnt;
    @(posedge clk);
    #1 cfg_stage_mask = 3'b000;
    cfg_start = 1'b1;
    @(posedge clk);
    #1 cfg_start = 1'b0;
    @(negedge clk);
    chk("zero_done_early", {63'd0, done}, 64'd0);
    chk("zero_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("zero_done", {63'd0, done}, 64'd1);
    chk("zero_idle", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    chk("zero_done_cnt", 64'(done_cnt - base), 64'd1);
    chk("zero_no_byp", {61'd0, byp_seen}, 64'd0);
    compare_writes("zero");

    // Abort after the third word of the 2.4 MHz stage
    gen_words(15);
    bypass_req = {1'($urandom), 2'b00};
    base = abort_cnt;
    start_cfg(3'b111);
    send_words(0, 3, 0);
    cfg_abort = 1'b1;
    @(posedge clk);
    #1 cfg_abort = 1'b0;
    @(negedge clk);
    chk("abort_pulse", {63'd0, aborted}, 64'd1);
    chk("abort_idle", {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    chk("abort_byp_2_4", {63'd0, bypass_2_4}, {63'd0, bypass_req[2]});
    chk("abort_cnt", 64'(abort_cnt - base), 64'd1);
    compare_writes("abort");
    bypass_req = 3'b000;
    run_reload(3'($urandom_range(1, 7)), 30, "post_abort");

    // User bypass held on the 1 MHz stage across its reload
    bypass_req = 3'b001;
    run_reload(3'b001, 20, "held");
    repeat (3) @(negedge clk);
    chk("held_byp_1", {63'd0, bypass_1}, 64'd1);
    chk("held_byp_2", {63'd0, bypass_2}, 64'd0);
    bypass_req = 3'b000;
    repeat (2) @(posedge clk);
    #1;

    // cfg_start while busy must not change the selection
    gen_words(5);
    plan(3'b100);
    start_cfg(3'b100);
    send_words(0, 2, 0);
    cfg_stage_mask = 3'b011;
    cfg_start = 1'b1;
    @(negedge clk);
    chk("busy_mid", {63'd0, busy}, 64'd1);
    @(posedge clk);
    #1 cfg_start = 1'b0;
    send_words(2, 5, 20);
    wait_done(2000);
    compare_writes("busy_start");

    // Random reloads
    for (int r = 0; r < 4; r++) begin
      run_reload(3'($urandom_range(1, 7)), int'($urandom_range(0, 50)), "rand");
    end

    // Reset during FLUSH
    base = done_cnt;
    gen_words(5);
    plan(3'b001);
    start_cfg(3'b001);
    send_words(0, 5, 0);
    t = 0;
    while (obs_q.size() == 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    compare_writes("pre_reset");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ctrl", ctrl_outs(), 64'd0);
    chk("rst_num", 64'(num_coeff_out), 64'd0);
    chk("rst_den", 64'(den_coeff_out), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    compare_writes("post_reset");
    chk("post_reset_done", 64'(done_cnt - base), 64'd0);
    chk("post_reset_ctrl", ctrl_outs(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iir_coeff_sequencer.md
Name: iir_coeff_sequencer

Overview:
- Configuration controller for the three-stage notch IIR chain (2.4 MHz, then 1 MHz, then 2 MHz).
- Accepts a reload request with a stage mask and a valid/ready stream of coefficient words.
- Collects five coefficients per selected stage, then pulses that stage's numerator and denominator write enables.
- Forces the stage into bypass while its coefficients are loaded and its state flushes, so no glitched output reaches downstream.

Parameters:
- COEFF_WIDTH, 20, coefficient word width (signed, passed through unmodified).
- FLUSH_SAMPLES, 2, valid_in strobes held in forced bypass after a write; 0 means no flush wait.
- FLUSH_CNT_W, 4, flush counter width; FLUSH_SAMPLES must be < 2**FLUSH_CNT_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  chain input sample strobe (counted during flush)
- cfg_start  in  1  start reload; ignored while busy=1
- cfg_stage_mask  in  3  bit2 = 2.4 MHz, bit1 = 2 MHz, bit0 = 1 MHz; sampled with cfg_start
- cfg_abort  in  1  abandon reload
- coeff_valid  in  1  coefficient word valid
- coeff_data  in  COEFF_WIDTH  signed coefficient word, order b0, b1, b2, a1, a2
- coeff_ready  out  1  sequencer accepts a word
- bypass_req  in  3  user bypass, same bit mapping as the mask
- bypass_2_4 / bypass_2 / bypass_1  out  1 each  to the chain
- num_coeff_out  out  3 x COEFF_WIDTH  shared numerator bus to all stages, [0]=b0
- den_coeff_out  out  2 x COEFF_WIDTH  shared denominator bus, [0]=a1
- num_coeff_2_4_wr_en, den_coeff_2_4_wr_en, num_coeff_2_wr_en, den_coeff_2_wr_en, num_coeff_1_wr_en, den_coeff_1_wr_en  out  1 each
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on reload completion
- aborted  out  1  one-cycle pulse when an abort takes effect

Behaviour:
- Reset:
  - All outputs are 0, coefficient buses are 0, state is IDLE, mask and counters are cleared.
  - Reset mid-operation discards the reload; no write enables pulse afterwards.
- Bypass outputs:
  - Each bypass output is registered: bypass_x = bypass_req_x | force_x.
  - Latency is 1 cycle from bypass_req or a force change.
- State IDLE:
  - coeff_ready=0.
  - On cfg_start with a nonzero mask, latch the mask and go to SELECT.
  - On cfg_start with a zero mask, go to DONE.
- State SELECT:
  - Pick the first pending stage in chain order: 2.4 MHz, then 1 MHz, then 2 MHz.
  - Set that stage's force bit, clear the word counter, go to COLLECT.
  - If no stage is pending, go to DONE.
- State COLLECT:
  - coeff_ready=1.
  - Each coeff_valid & coeff_ready stores coeff_data in slot cnt (0–2 numerator, 3–4 denominator) and increments cnt.
  - Handshake on cnt=4 goes to WRITE.
  - coeff_valid low simply stalls; there is no timeout.
- State WRITE (exactly 1 cycle):
  - coeff_ready=0.
  - Both wr_en outputs of the selected stage are 1; all other wr_en outputs are 0.
  - Buses hold the collected values; they hold until overwritten by the next collect.
  - Clear the flush counter, go to FLUSH.
- State FLUSH:
  - Count valid_in strobes.
  - When count reaches FLUSH_SAMPLES, clear the force bit and the mask bit, then go to SELECT.
  - With FLUSH_SAMPLES=0, FLUSH lasts 1 cycle.
- State DONE: done=1 for one cycle, then go to IDLE.
- Abort:
  - cfg_abort in any state except IDLE goes to IDLE next cycle.
  - aborted pulses, all force bits clear, mask clears, no wr_en is issued.
  - Abort has priority over every transition, including WRITE; a concurrent handshake word is discarded.
- Only one stage is ever forced or written at a time.
- No arithmetic is performed; word widths are preserved and sign is untouched.

Decomposition:
- Shared package iir_cfg_pkg:
  - stage index constants: IIR_2_4_NOTCH=2, IIR_2_NOTCH=1, IIR_1_NOTCH=0
  - NUM_COEFF_DEPTH=3, DEN_COEFF_DEPTH=2
  - words-per-stage constant = 5
  - state enum seq_state_t {IDLE, SELECT, COLLECT, WRITE, FLUSH, DONE}
- No sub-module. The flush counter and the word collector are inline.

Test Plan:
- Mask 3'b111, 15 words streamed back-to-back, FLUSH_SAMPLES=2, valid_in every 4 cycles:
  - Stages are written in order 2.4 MHz, 1 MHz, 2 MHz.
  - Each stage gets a one-cycle wr_en pair with buses matching its 5 words.
  - Each force bypass rises 1 cycle after SELECT and falls after 2 valid_in strobes.
  - done pulses once.
- Mask 3'b010, words 0x0FFFF, 0x80000, 0x7FFFF, 0xC0000, 0x00001 with coeff_valid gaps:
  - Only the 2 MHz wr_en pulses; buses reflect the words exactly, including the negative values.
  - bypass_2_4 and bypass_1 never assert.
- Mask 3'b000: done pulses 2 cycles after cfg_start; no wr_en; no bypass change.
- Abort after the 3rd word of stage 2.4 MHz:
  - aborted pulses, no wr_en, bypass_2_4 returns to bypass_req[2], busy drops.
  - A following cfg_start is accepted.
- bypass_req[0]=1 throughout a 1 MHz reload: bypass_1 stays 1 after force release.
- cfg_start asserted while busy is ignored (mask unchanged).
- rst_n low during FLUSH: all outputs are 0 immediately; no later wr_en.
